// File: rtl/shake_coef_unpacker.sv
// Squeeze-side consumer for the SHAKE256 core: starts the sponge with the byte
// length for N_COEF coefficients, then repacks the 64-bit squeeze stream
// little-endian into COEF_W-bit coefficients on a valid/ready stream.
module shake_coef_unpacker #(
    parameter int COEF_W = 13,
    parameter int N_COEF = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              shk_start,
    output logic [12:0]       shk_out_len,
    input  logic [63:0]       shk_data,
    input  logic [7:0]        shk_keep,
    input  logic              shk_valid,
    output logic              shk_ready,
    input  logic              shk_last,
    input  logic              shk_done,
    output logic [COEF_W-1:0] coef,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              coef_last
);
    localparam int                BUF_W     = COEF_W + 63;
    localparam int                CCNT_W    = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam logic [12:0]       OUT_BYTES = 13'((N_COEF * COEF_W + 7) / 8);
    localparam logic [6:0]        COEF_W7   = 7'(COEF_W);
    localparam logic [CCNT_W-1:0] CCNT_LAST = CCNT_W'(N_COEF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_WAIT,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  bits_q, bits_d;
    logic [6:0]        bcnt_q, bcnt_d;
    logic [CCNT_W-1:0] ccnt_q, ccnt_d;
    logic [13:0]       byte_cnt_q, byte_cnt_d;
    logic              last_seen_q, last_seen_d;
    logic              err_q, err_d;

    logic [3:0]        kept_n;
    logic              keep_found;
    logic              keep_gap;
    logic [63:0]       data_kept;

    // Outputs are pure functions of registered state, so they never glitch on inputs.
    assign busy        = (state_q != S_IDLE);
    assign shk_start   = (state_q == S_START);
    assign done        = (state_q == S_FIN);
    assign err         = err_q;
    assign shk_out_len = OUT_BYTES;
    assign coef        = bits_q[COEF_W-1:0];
    assign coef_valid  = (state_q == S_RUN) && (bcnt_q >= COEF_W7);
    assign shk_ready   = (state_q == S_RUN) && (bcnt_q < COEF_W7) && !last_seen_q;
    assign coef_last   = coef_valid && (ccnt_q == CCNT_LAST);

    // Decode the keep mask: kept bytes = index of the first zero, anything set above it is a gap.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
        kept_n     = 4'd8;
        keep_found = 1'b0;
        keep_gap   = 1'b0;
        data_kept  = '0;
        for (int i = 0; i < 8; i++) begin
            if (!shk_keep[i] && !keep_found) begin
                kept_n     = 4'(i);
                keep_found = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < kept_n) begin
                data_kept[8*i +: 8] = shk_data[8*i +: 8];
            end else if (shk_keep[i]) begin
                keep_gap = 1'b1;
            end
        end
    end

    // Next-state logic for the control FSM and the bit buffer.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later lines see the updated value (byte_cnt_d below).
        state_d     = state_q;
        bits_d      = bits_q;
        bcnt_d      = bcnt_q;
        ccnt_d      = ccnt_q;
        byte_cnt_d  = byte_cnt_q;
        last_seen_d = last_seen_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    bits_d      = '0;
                    bcnt_d      = '0;
                    ccnt_d      = '0;
                    byte_cnt_d  = '0;
                    last_seen_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = S_START;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                // Ready and valid are mutually exclusive on bcnt, so at most one branch transfers.
                if (shk_valid && shk_ready) begin
                    bits_d     = bits_q | (BUF_W'(data_kept) << bcnt_q);
                    bcnt_d     = bcnt_q + {kept_n, 3'b000};
                    byte_cnt_d = byte_cnt_q + 14'(kept_n);
                    if (keep_gap) err_d = 1'b1;
                    if (shk_last) begin
                        last_seen_d = 1'b1;
                        if (byte_cnt_d != 14'(OUT_BYTES)) err_d = 1'b1;
                    end
                end else if (coef_valid && coef_ready) begin
                    if (coef_last) begin
                        // Fewer than 8 padding bits remain; drop them.
                        bits_d  = '0;
                        bcnt_d  = '0;
                        state_d = S_WAIT;
                    end else begin
                        bits_d = bits_q >> COEF_W;
                        bcnt_d = bcnt_q - COEF_W7;
                        ccnt_d = ccnt_q + 1'b1;
                    end
                end else if (last_seen_q && (bcnt_q < COEF_W7)) begin
                    // Stream ended before all coefficients could be formed.
                    err_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT:  if (shk_done) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            // NOTE: the bit buffer is reset too, because coef reads it directly and must be 0 out of reset.
            bits_q      <= '0;
            bcnt_q      <= '0;
            ccnt_q      <= '0;
            byte_cnt_q  <= '0;
            last_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
            state_q     <= state_d;
            bits_q      <= bits_d;
            bcnt_q      <= bcnt_d;
            ccnt_q      <= ccnt_d;
            byte_cnt_q  <= byte_cnt_d;
            last_seen_q <= last_seen_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_shake_coef_unpacker.sv
// Directed bench for shake_coef_unpacker: a 4-coefficient instance for
// cycle-exact checks and a 256-coefficient instance against a bit-serial model.
module tb_shake_coef_unpacker;

    logic clk;
    logic rst_n;

    // Small instance: COEF_W=13, N_COEF=4 (OUT_BYTES=7)
    logic        a_req, a_busy, a_done, a_err, a_shk_start;
    logic [12:0] a_shk_out_len;
    logic [63:0] a_shk_data;
    logic [7:0]  a_shk_keep;
    logic        a_shk_valid, a_shk_ready, a_shk_last, a_shk_done;
    logic [12:0] a_coef;
    logic        a_coef_valid, a_coef_ready, a_coef_last;

    // Full instance: COEF_W=13, N_COEF=256 (OUT_BYTES=416)
    logic        b_req, b_busy, b_done, b_err, b_shk_start;
    logic [12:0] b_shk_out_len;
    logic [63:0] b_shk_data;
    logic [7:0]  b_shk_keep;
    logic        b_shk_valid, b_shk_ready, b_shk_last, b_shk_done;
    logic [12:0] b_coef;
    logic        b_coef_valid, b_coef_ready, b_coef_last;

    int checks = 0;
    int errors = 0;

    logic [7:0] beat_keep [64];
    logic       beat_last [64];

    shake_coef_unpacker #(.COEF_W(13), .N_COEF(4)) u_small (
        .clk(clk), .rst_n(rst_n), .req(a_req), .busy(a_busy), .done(a_done), .err(a_err),
        .shk_start(a_shk_start), .shk_out_len(a_shk_out_len), .shk_data(a_shk_data),
        .shk_keep(a_shk_keep), .shk_valid(a_shk_valid), .shk_ready(a_shk_ready),
        .shk_last(a_shk_last), .shk_done(a_shk_done), .coef(a_coef),
        .coef_valid(a_coef_valid), .coef_ready(a_coef_ready), .coef_last(a_coef_last)
    );

    shake_coef_unpacker #(.COEF_W(13), .N_COEF(256)) u_full (
        .clk(clk), .rst_n(rst_n), .req(b_req), .busy(b_busy), .done(b_done), .err(b_err),
        .shk_start(b_shk_start), .shk_out_len(b_shk_out_len), .shk_data(b_shk_data),
        .shk_keep(b_shk_keep), .shk_valid(b_shk_valid), .shk_ready(b_shk_ready),
        .shk_last(b_shk_last), .shk_done(b_shk_done), .coef(b_coef),
        .coef_valid(b_coef_valid), .coef_ready(b_coef_ready), .coef_last(b_coef_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_chk_reset(input string tag);
        chk({tag, "_busy"},       a_busy,        64'd0);
        chk({tag, "_done"},       a_done,        64'd0);
        chk({tag, "_err"},        a_err,         64'd0);
        chk({tag, "_start"},      a_shk_start,   64'd0);
        chk({tag, "_shk_ready"},  a_shk_ready,   64'd0);
        chk({tag, "_coef_valid"}, a_coef_valid,  64'd0);
        chk({tag, "_coef_last"},  a_coef_last,   64'd0);
        chk({tag, "_coef"},       a_coef,        64'd0);
        chk({tag, "_out_len"},    a_shk_out_len, 64'd7);
    endtask

    // One complete request on the small instance with a single 7-byte beat.
    task automatic a_run(input string tag);
        logic [12:0] exp_c [4];
        exp_c[0] = 13'h0DEF;
        exp_c[1] = 13'h0D5E;
        exp_c[2] = 13'h19E2;
        exp_c[3] = 13'h068A;
        a_req = 1'b1;
        tick();
        chk({tag, "_start"}, a_shk_start, 64'd1);
        chk({tag, "_busy"},  a_busy,      64'd1);
        a_req = 1'b0;
        tick();
        chk({tag, "_start_off"}, a_shk_start, 64'd0);
        chk({tag, "_ready"},     a_shk_ready, 64'd1);
        a_shk_data  = 64'h0123456789ABCDEF;
        a_shk_keep  = 8'h7F;
        a_shk_last  = 1'b1;
        a_shk_valid = 1'b1;
        tick();
        a_shk_valid = 1'b0;
        a_shk_last  = 1'b0;
        chk({tag, "_cv"},       a_coef_valid, 64'd1);
        chk({tag, "_rdy_low"},  a_shk_ready,  64'd0);
        chk({tag, "_c0"},       a_coef,       64'h0DEF);
        a_coef_ready = 1'b0;
        tick();
        chk({tag, "_stall_cv"}, a_coef_valid, 64'd1);
        chk({tag, "_stall_c0"}, a_coef,       64'h0DEF);
        a_coef_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_coef%0d", tag, k), a_coef, 64'(exp_c[k]));
            chk($sformatf("%s_last%0d", tag, k), a_coef_last, 64'(k == 3));
            tick();
        end
        a_coef_ready = 1'b0;
        chk({tag, "_wait_cv"},   a_coef_valid, 64'd0);
        chk({tag, "_wait_busy"}, a_busy,       64'd1);
        chk({tag, "_wait_done"}, a_done,       64'd0);
        a_shk_done = 1'b1;
        tick();
        chk({tag, "_done"}, a_done, 64'd1);
        a_shk_done = 1'b0;
        tick();
        chk({tag, "_done_off"}, a_done, 64'd0);
        chk({tag, "_idle"},     a_busy, 64'd0);
        chk({tag, "_err"},      a_err,  64'd0);
    endtask

    // Request on the full instance, streaming nb beats from beat_keep/beat_last with
    // random data and random coef_ready, comparing against a bit-serial model.
    task automatic b_run(input string tag, input int nb, input int exp_n, input logic exp_err);
        bit          q[$];
        int          sent, got, lasts, dones, starts, cyc;
        logic        stalled;
        logic [12:0] held, m;
        logic [63:0] d;
        q.delete();
        sent = 0; got = 0; lasts = 0; dones = 0; starts = 0; cyc = 0;
        stalled = 1'b0;
        held = '0;
        b_req = 1'b1;
        tick();
        chk({tag, "_start"}, b_shk_start, 64'd1);
        b_req = 1'b0;
        tick();
        while (cyc < 4000 && !(dones > 0 && !b_busy)) begin
            if (stalled) begin
                chk({tag, "_stall_cv"},   b_coef_valid, 64'd1);
                chk({tag, "_stall_coef"}, b_coef,       64'(held));
            end
            if (b_shk_start) starts++;
            if (b_done) dones++;
            b_req = (cyc == 3);
            if (b_shk_ready && sent < nb) begin
                d = {$urandom, $urandom};
                b_shk_valid = 1'b1;
                b_shk_data  = d;
                b_shk_keep  = beat_keep[sent];
                b_shk_last  = beat_last[sent];
                for (int j = 0; j < 8; j++) begin
                    if (beat_keep[sent][j]) begin
                        for (int t = 0; t < 8; t++) q.push_back(d[8*j + t]);
                    end
                end
                sent++;
            end else begin
                b_shk_valid = 1'b0;
                b_shk_last  = 1'b0;
            end
            b_coef_ready = 1'($urandom_range(0, 1));
            if (b_coef_valid && b_coef_ready) begin
                for (int j = 0; j < 13; j++) m[j] = (q.size() > 0) ? q.pop_front() : 1'b0;
                chk($sformatf("%s_coef%0d", tag, got), b_coef, 64'(m));
                chk($sformatf("%s_last%0d", tag, got), b_coef_last, 64'(got == 255));
                if (b_coef_last) lasts++;
                got++;
            end
            stalled = b_coef_valid && !b_coef_ready;
            held    = b_coef;
            b_shk_done = (sent == nb) && !b_coef_valid && (dones == 0);
            tick();
            cyc++;
        end
        b_req        = 1'b0;
        b_shk_valid  = 1'b0;
        b_shk_done   = 1'b0;
        b_coef_ready = 1'b0;
        chk({tag, "_in_budget"}, 64'(cyc < 4000), 64'd1);
        chk({tag, "_ncoef"},     64'(got),        64'(exp_n));
        chk({tag, "_nlast"},     64'(lasts),      exp_err ? 64'd0 : 64'd1);
        chk({tag, "_ndone"},     64'(dones),      64'd1);
        chk({tag, "_restart"},   64'(starts),     64'd0);
        chk({tag, "_err"},       b_err,           64'(exp_err));
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_shk_data = '0; a_shk_keep = '0; a_shk_valid = 1'b0;
        a_shk_last = 1'b0; a_shk_done = 1'b0; a_coef_ready = 1'b0;
        b_req = 1'b0; b_shk_data = '0; b_shk_keep = '0; b_shk_valid = 1'b0;
        b_shk_last = 1'b0; b_shk_done = 1'b0; b_coef_ready = 1'b0;
        repeat (3) tick();
        a_chk_reset("rst");
        chk("rst_b_out_len", b_shk_out_len, 64'd416);
        chk("rst_b_busy",    b_busy,        64'd0);
        rst_n = 1'b1;
        tick();

        a_run("small");

        // 52 full beats, last flagged on the final one
        for (int i = 0; i < 64; i++) begin
            beat_keep[i] = 8'hFF;
            beat_last[i] = (i == 51);
        end
        b_run("full", 52, 256, 1'b0);

        // Early shk_last on beat 2: 128 bits yield 9 coefficients
        for (int i = 0; i < 64; i++) begin
            beat_keep[i] = 8'hFF;
            beat_last[i] = (i == 1);
        end
        b_run("early", 2, 9, 1'b1);

        // Half beat mid-stream: 64+32+64 = 160 bits yield 12 coefficients
        for (int i = 0; i < 64; i++) begin
            beat_keep[i] = (i == 1) ? 8'h0F : 8'hFF;
            beat_last[i] = (i == 2);
        end
        b_run("keep", 3, 12, 1'b1);

        // Reset while a coefficient is presented
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
        tick();
        a_shk_data  = 64'h0123456789ABCDEF;
        a_shk_keep  = 8'h7F;
        a_shk_last  = 1'b1;
        a_shk_valid = 1'b1;
        tick();
        a_shk_valid = 1'b0;
        a_shk_last  = 1'b0;
        chk("mid_pre_cv", a_coef_valid, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        a_chk_reset("mid");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_start", a_shk_start, 64'd0);
        chk("post_rst_done",  a_done,      64'd0);
        chk("post_rst_busy",  a_busy,      64'd0);
        a_run("again");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
